// File: rtl/counting_sched.sv
// Round-robin scheduler sharing one 2-bit token detector among N streams.
// Each stream keeps its own detector context and a registered sticky ans flag.
module counting_sched #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [2*N-1:0]  num,
  input  logic [N-1:0]    clr,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic [N-1:0]    ans,
  output logic            busy
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic [1:0]    r_st [N];
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_ans;

  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_gntId;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic [1:0]    w_curSt;
  logic [1:0]    w_tok;
  logic [1:0]    w_fNext;
  logic [1:0]    w_stNext [N];
  logic [IW-1:0] w_ptrNext;

  // Search from r_ptr with wraparound; the first requester found wins.
  always_comb begin
    w_gnt   = '0;
    w_gntId = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < N; off++) begin
      w_idx = IW'((int'(r_ptr) + off) % N);
      if (!w_found && req[w_idx]) begin
        w_found       = 1'b1;
        w_gnt[w_idx]  = 1'b1;
        w_gntId       = w_idx;
      end
    end
  end

  assign w_curSt = r_st[w_gntId];
  assign w_tok   = num[{w_gntId, 1'b0} +: 2];

  always_comb begin
    w_fNext = w_curSt;
    case (w_curSt)
      S0: w_fNext = (w_tok == 2'b01) ? S1 : S0;
      S1: begin
        case (w_tok)
          2'b10:   w_fNext = S2;
          2'b11:   w_fNext = S0;
          default: w_fNext = S1;
        endcase
      end
      S2: begin
        case (w_tok)
          2'b00:   w_fNext = S2;
          2'b01:   w_fNext = S1;
          2'b10:   w_fNext = S0;
          default: w_fNext = S3;
        endcase
      end
      default: w_fNext = S3;
    endcase
  end

  // clr overrides the detector result, so a colliding token is discarded.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_stNext[i] = r_st[i];
      if (w_found && (w_gntId == IW'(i)))
        w_stNext[i] = w_fNext;
      if (clr[i])
        w_stNext[i] = S0;
    end
  end

  assign w_ptrNext = (w_gntId == IW'(N - 1)) ? '0 : w_gntId + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        r_st[i] <= S0;
      r_ptr <= '0;
      r_ans <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_st[i]  <= w_stNext[i];
        r_ans[i] <= (w_stNext[i] == S3);
      end
      if (w_found)
        r_ptr <= w_ptrNext;
    end
  end

  assign gnt    = w_gnt;
  assign gnt_id = w_gntId;
  assign ans    = r_ans;
  assign busy   = |req;

endmodule

// File: tb/tb_counting_sched.sv
// Self-checking bench for counting_sched (N=4): a behavioural model feeds an
// expected-value queue that each scenario drains against observed outputs.
module tb_counting_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] num;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] ans;
  logic       busy;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic [3:0] a;
  } cyc_t;

  cyc_t expQ[$];
  cyc_t obsQ[$];
  cyc_t e;
  cyc_t o;

  int checks = 0;
  int passes = 0;

  // Reference detector table indexed by state*4 + token.
  int fTab[16] = '{0, 1, 0, 0,  1, 1, 2, 0,  2, 1, 0, 3,  3, 3, 3, 3};
  int mSt[4];
  int mPtr;

  logic [3:0] lastGnt;
  logic [1:0] lastId;
  logic       lastBusy;
  logic [3:0] lastAns;

  counting_sched #(.N(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .num    (num),
    .clr    (clr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .ans    (ans),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mSt[i] = 0;
    mPtr = 0;
  endtask

  // One cycle: drive at negedge, sample comb outputs, advance model at posedge.
  task automatic driveCycle(input logic [3:0] rq, input logic [7:0] nm, input logic [3:0] cl);
    int k;
    @(negedge clk);
    req = rq; num = nm; clr = cl;
    #1;
    k = -1;
    for (int j = 0; j < 4; j++)
      if (k < 0 && rq[(mPtr + j) % 4]) k = (mPtr + j) % 4;
    e.g  = (k >= 0) ? (4'b0001 << k) : 4'b0000;
    e.id = (k >= 0) ? 2'(k) : 2'd0;
    e.b  = |rq;
    o.g = gnt; o.id = gnt_id; o.b = busy;
    lastGnt = gnt; lastId = gnt_id; lastBusy = busy;
    @(posedge clk);
    if (rst_n) begin
      if (k >= 0) begin
        mSt[k] = fTab[mSt[k] * 4 + int'(nm[2*k +: 2])];
        mPtr = (k + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (cl[i]) mSt[i] = 0;
    end
    #1;
    for (int i = 0; i < 4; i++) e.a[i] = (mSt[i] == 3);
    o.a = ans;
    lastAns = ans;
    expQ.push_back(e);
    obsQ.push_back(o);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; num = '0; clr = '0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] toks [5] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h02};
    logic       expA [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b0; req = '0; num = '0; clr = '0;
    modelReset();
    #12;
    checks++; if (ans !== 4'b0000) $display("[TB] FAIL reset_ans: got %b expected 0000", ans); else passes++;
    checks++; if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); else passes++;
    checks++; if (gnt_id !== 2'd0) $display("[TB] FAIL reset_gnt_id: got %0d expected 0", gnt_id); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      driveCycle(4'b0001, toks[c], 4'b0000);
      checks++; if (lastGnt !== 4'b0001) $display("[TB] FAIL single_gnt[%0d]: got %b expected 0001", c, lastGnt); else passes++;
      checks++; if (lastAns[0] !== expA[c]) $display("[TB] FAIL single_ans0[%0d]: got %b expected %b", c, lastAns[0], expA[c]); else passes++;
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL single_cycle: got g=%b id=%0d b=%b a=%b expected g=%b id=%0d b=%b a=%b", o.g, o.id, o.b, o.a, e.g, e.id, e.b, e.a);
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seqA [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] seqB [3] = '{2'd1, 2'd3, 2'd1};
    doReset();
    for (int c = 0; c < 5; c++) begin
      driveCycle(4'b1111, 8'h00, 4'b0000);
      checks++; if (lastId !== seqA[c]) $display("[TB] FAIL rr_all[%0d]: got %0d expected %0d", c, lastId, seqA[c]); else passes++;
    end
    for (int c = 0; c < 3; c++) begin
      driveCycle(4'b1010, 8'h00, 4'b0000);
      checks++; if (lastId !== seqB[c]) $display("[TB] FAIL rr_1010[%0d]: got %0d expected %0d", c, lastId, seqB[c]); else passes++;
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL rr_cycle: got g=%b id=%0d b=%b a=%b expected g=%b id=%0d b=%b a=%b", o.g, o.id, o.b, o.a, e.g, e.id, e.b, e.a);
      else passes++;
    end
  endtask

  task automatic test_isolation();
    // Tokens for {stream2, stream0} presented each cycle, held until granted.
    logic [1:0] s0 [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [1:0] s2 [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
    logic [3:0] rq [5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001};
    logic [1:0] ids [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    doReset();
    for (int c = 0; c < 5; c++) begin
      driveCycle(rq[c], {2'b00, s2[c], 2'b00, s0[c]}, 4'b0000);
      checks++; if (lastId !== ids[c]) $display("[TB] FAIL iso_gnt_id[%0d]: got %0d expected %0d", c, lastId, ids[c]); else passes++;
    end
    checks++; if (lastAns !== 4'b0001) $display("[TB] FAIL iso_ans: got %b expected 0001", lastAns); else passes++;
    driveCycle(4'b0100, 8'b0011_0000, 4'b0000);
    checks++; if (lastAns !== 4'b0001) $display("[TB] FAIL iso_st2_s0: got %b expected 0001", lastAns); else passes++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL iso_cycle: got g=%b id=%0d b=%b a=%b expected g=%b id=%0d b=%b a=%b", o.g, o.id, o.b, o.a, e.g, e.id, e.b, e.a);
      else passes++;
    end
  endtask

  task automatic test_clr_collision();
    doReset();
    driveCycle(4'b0010, 8'b0000_0100, 4'b0000);
    driveCycle(4'b0010, 8'b0000_1000, 4'b0000);
    driveCycle(4'b0010, 8'b0000_1100, 4'b0010);
    checks++; if (lastAns[1] !== 1'b0) $display("[TB] FAIL clr_ans1: got %b expected 0", lastAns[1]); else passes++;
    driveCycle(4'b0110, 8'b0000_1100, 4'b0000);
    checks++; if (lastId !== 2'd2) $display("[TB] FAIL clr_next_gnt: got %0d expected 2", lastId); else passes++;
    driveCycle(4'b0010, 8'b0000_1100, 4'b0000);
    checks++; if (lastAns[1] !== 1'b0) $display("[TB] FAIL clr_st1_s0: got %b expected 0", lastAns[1]); else passes++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL clr_cycle: got g=%b id=%0d b=%b a=%b expected g=%b id=%0d b=%b a=%b", o.g, o.id, o.b, o.a, e.g, e.id, e.b, e.a);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    driveCycle(4'b0001, 8'h01, 4'b0000);
    driveCycle(4'b0001, 8'h02, 4'b0000);
    driveCycle(4'b0001, 8'h03, 4'b0000);
    driveCycle(4'b1000, 8'b0100_0000, 4'b0000);
    driveCycle(4'b1000, 8'b1000_0000, 4'b0000);
    checks++; if (lastAns !== 4'b0001) $display("[TB] FAIL mid_pre_ans: got %b expected 0001", lastAns); else passes++;
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = 4'b1000;
    modelReset();
    #1;
    checks++; if (ans !== 4'b0000) $display("[TB] FAIL mid_async_ans: got %b expected 0000", ans); else passes++;
    checks++; if (gnt !== 4'b1000) $display("[TB] FAIL mid_rst_gnt: got %b expected 1000", gnt); else passes++;
    #1 rst_n = 1'b1;
    driveCycle(4'b1000, 8'b1100_0000, 4'b0000);
    checks++; if (lastAns[3] !== 1'b0) $display("[TB] FAIL mid_post_ans3: got %b expected 0", lastAns[3]); else passes++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL mid_cycle: got g=%b id=%0d b=%b a=%b expected g=%b id=%0d b=%b a=%b", o.g, o.id, o.b, o.a, e.g, e.id, e.b, e.a);
      else passes++;
    end
  endtask

  task automatic test_idle();
    driveCycle(4'b0010, 8'h00, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      driveCycle(4'b0000, 8'h00, 4'b0000);
      checks++; if (lastGnt !== 4'b0000) $display("[TB] FAIL idle_gnt[%0d]: got %b expected 0000", c, lastGnt); else passes++;
      checks++; if (lastId !== 2'd0) $display("[TB] FAIL idle_gnt_id[%0d]: got %0d expected 0", c, lastId); else passes++;
      checks++; if (lastBusy !== 1'b0) $display("[TB] FAIL idle_busy[%0d]: got %b expected 0", c, lastBusy); else passes++;
    end
    driveCycle(4'b1111, 8'h00, 4'b0000);
    checks++; if (lastId !== 2'd2) $display("[TB] FAIL idle_ptr_held: got %0d expected 2", lastId); else passes++;
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL idle_cycle: got g=%b id=%0d b=%b a=%b expected g=%b id=%0d b=%b a=%b", o.g, o.id, o.b, o.a, e.g, e.id, e.b, e.a);
      else passes++;
    end
  endtask

  initial begin
    $display("[TB] starting counting_sched bench");
    test_reset();
    test_round_robin();
    test_isolation();
    test_clr_collision();
    test_mid_reset();
    test_idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
